// File: rtl/intt_output_collector.sv
// Collects the INTT router's final-layer output (4 coefficients per core per beat) and drains the
// whole polynomial as a valid/ready stream. Define INTT_COLLECT_BITREV_EN for bit-reversed drain order.
module intt_output_collector #(
    parameter int LOG_CORE_COUNT = 5,
    parameter int LOG_N          = 12
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          in_valid,
    input  logic [(1<<LOG_CORE_COUNT)-1:0][1:0][59:0]     in_data,
    input  logic [8:0]                                    in_address,
    output logic                                          busy,
    output logic                                          overflow,
    output logic [29:0]                                   m_data,
    output logic                                          m_valid,
    input  logic                                          m_ready,
    output logic                                          m_last
);
    localparam int CORES     = 1 << LOG_CORE_COUNT;
    localparam int LOG_W     = LOG_N - LOG_CORE_COUNT;
    localparam int WORDS     = 1 << LOG_W;
    localparam int LOG_BEATS = LOG_W - 2;

    typedef enum logic [0:0] {COLLECT = 1'b0, DRAIN = 1'b1} state_t;

    state_t                 state_r, state_next_s;
    logic [LOG_BEATS-1:0]   beat_cnt_r;
    logic [LOG_N:0]         rd_idx_r;
    logic [29:0]            mem_r [CORES][WORDS];
    logic [LOG_BEATS-1:0]   wr_addr_s;
    logic [LOG_N-1:0]       rd_coef_s;
    logic [29:0]            rd_word_s;
    logic                   rd_last_s;
    logic                   issue_s, out_free_s, done_s, wr_en_s;
    logic                   busy_r, overflow_r, m_valid_r, m_last_r;
    logic [29:0]            m_data_r;
    logic                   skid_valid_r, skid_last_r;
    logic [29:0]            skid_data_r;
    logic                   unused_addr_s;

`ifdef INTT_COLLECT_BITREV_EN
    function automatic logic [LOG_N-1:0] bitrev(input logic [LOG_N-1:0] v);
        logic [LOG_N-1:0] r;
        for (int i = 0; i < LOG_N; i++) r[i] = v[LOG_N-1-i];
        return r;
    endfunction
    assign rd_coef_s = bitrev(rd_idx_r[LOG_N-1:0]);
`else
    assign rd_coef_s = rd_idx_r[LOG_N-1:0];
`endif

    // Only the low address bits select a beat within a core's 128-word bank.
    assign wr_addr_s     = in_address[LOG_BEATS-1:0];
    assign unused_addr_s = ^in_address[8:LOG_BEATS];
    assign wr_en_s       = (state_r == COLLECT) && in_valid;

    assign rd_word_s  = mem_r[rd_coef_s[LOG_N-1:LOG_W]][rd_coef_s[LOG_W-1:0]];
    assign rd_last_s  = (rd_idx_r[LOG_N-1:0] == {LOG_N{1'b1}});
    // A read is issued only when the skid slot is free, so a stalled output never loses data.
    assign issue_s    = (state_r == DRAIN) && !rd_idx_r[LOG_N] && !skid_valid_r;
    assign out_free_s = !m_valid_r || m_ready;
    assign done_s     = m_valid_r && m_ready && m_last_r;

    // Next-state logic for the collect/drain FSM.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            COLLECT: begin
                if (in_valid && (beat_cnt_r == {LOG_BEATS{1'b1}})) state_next_s = DRAIN;
                else                                                state_next_s = COLLECT;
            end
            DRAIN: begin
                if (done_s) state_next_s = COLLECT;
                else        state_next_s = DRAIN;
            end
            default: state_next_s = COLLECT;
        endcase
    end

    // Coefficient storage; not reset, each frame fully rewrites it.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            for (int k = 0; k < CORES; k++) begin
                for (int s = 0; s < 2; s++) begin
                    mem_r[k][{wr_addr_s, s[0], 1'b0}] <= in_data[k][s][29:0];
                    mem_r[k][{wr_addr_s, s[0], 1'b1}] <= in_data[k][s][59:30];
                end
            end
        end
    end

    // State, counters, status flags and the registered-read/skid output path.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= COLLECT;
            beat_cnt_r   <= {LOG_BEATS{1'b0}};
            rd_idx_r     <= {(LOG_N+1){1'b0}};
            busy_r       <= 1'b0;
            overflow_r   <= 1'b0;
            m_valid_r    <= 1'b0;
            m_last_r     <= 1'b0;
            m_data_r     <= 30'd0;
            skid_valid_r <= 1'b0;
            skid_last_r  <= 1'b0;
            skid_data_r  <= 30'd0;
        end else begin
            state_r    <= state_next_s;
            busy_r     <= (state_next_s == DRAIN);
            overflow_r <= overflow_r | (in_valid && (state_r == DRAIN));
            if (wr_en_s) beat_cnt_r <= beat_cnt_r + 1'b1;
            else         beat_cnt_r <= beat_cnt_r;
            if (done_s)       rd_idx_r <= {(LOG_N+1){1'b0}};
            else if (issue_s) rd_idx_r <= rd_idx_r + 1'b1;
            else              rd_idx_r <= rd_idx_r;
            if (out_free_s) begin
                if (skid_valid_r) begin
                    m_valid_r    <= 1'b1;
                    m_data_r     <= skid_data_r;
                    m_last_r     <= skid_last_r;
                    skid_valid_r <= 1'b0;
                end else if (issue_s) begin
                    m_valid_r <= 1'b1;
                    m_data_r  <= rd_word_s;
                    m_last_r  <= rd_last_s;
                end else begin
                    m_valid_r <= 1'b0;
                    m_last_r  <= 1'b0;
                end
            end else if (issue_s) begin
                skid_valid_r <= 1'b1;
                skid_data_r  <= rd_word_s;
                skid_last_r  <= rd_last_s;
            end else begin
                skid_valid_r <= skid_valid_r;
            end
        end
    end

    assign busy     = busy_r;
    assign overflow = overflow_r;
    assign m_valid  = m_valid_r;
    assign m_data   = m_data_r;
    assign m_last   = m_last_r;

endmodule

// File: tb/tb_intt_output_collector.sv
// Scoreboard bench for intt_output_collector: frame loads from a scenario table, drained output
// popped from an expected-value queue; honours INTT_COLLECT_BITREV_EN for the expected order.
module tb_intt_output_collector;
    localparam int CORES = 32;
    localparam int N     = 4096;

    logic                         clk = 1'b0;
    logic                         rst_n, in_valid, busy, overflow, m_valid, m_ready, m_last;
    logic [CORES-1:0][1:0][59:0]  in_data;
    logic [8:0]                   in_address;
    logic [29:0]                  m_data;

    intt_output_collector dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_address(in_address), .busy(busy), .overflow(overflow), .m_data(m_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last)
    );

    always #5 clk = ~clk;

    typedef struct { logic [29:0] data; logic last; } exp_t;
    typedef struct {
        bit rev_addr; int salt; int ready_pct; int ovf_beat; int rst_beat;
        int exp_cycles; logic exp_ovf;
    } scen_t;

    exp_t        sbq[$];
    logic [29:0] model_mem [N];
    int          n_cmp = 0, n_fail = 0;
    int          pop_cnt = 0, ready_pct = 100;
    bit          mon_en = 1'b0, prev_stall = 1'b0, prev_last = 1'b0;
    logic [29:0] prev_data = 30'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [29:0] val(input int c, input int salt);
        return 30'(c + salt * 4096);
    endfunction

    function automatic int ord(input int i);
`ifdef INTT_COLLECT_BITREV_EN
        logic [11:0] v, r;
        v = 12'(i);
        for (int b = 0; b < 12; b++) r[b] = v[11-b];
        return int'(r);
`else
        return i;
`endif
    endfunction

    // One accepted beat: update the reference memory and drive the router-side inputs.
    task automatic send_beat(input int a, input int salt);
        int c;
        for (int k = 0; k < CORES; k++) begin
            c = k * 128 + 4 * (a % 32);
            for (int j = 0; j < 4; j++) model_mem[c+j] = val(c + j, salt);
            in_data[k][0] = {val(c + 1, salt), val(c, salt)};
            in_data[k][1] = {val(c + 3, salt), val(c + 2, salt)};
        end
        in_address = 9'(a + 32 * (salt % 16));
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic push_expected();
        exp_t e;
        for (int i = 0; i < N; i++) begin
            e.data = model_mem[ord(i)];
            e.last = (i == N - 1);
            sbq.push_back(e);
        end
    endtask

    task automatic drain(input int ovf_beat, input int rst_beat, input int exp_cycles);
        int n = 0;
        bit inj = 1'b0, pend = 1'b0, done = 1'b0;
        while (!done && n < 20000) begin
            @(posedge clk); #1;
            n++;
            if (exp_cycles > 0 && n == 1) chk("first_valid", m_valid, 1);
            if (pend) begin
                in_valid = 1'b0;
                pend = 1'b0;
                chk("overflow_rise", overflow, 1);
            end
            if (ovf_beat >= 0 && !inj && pop_cnt >= ovf_beat) begin
                for (int k = 0; k < CORES; k++) in_data[k] = {2{60'hFFF_FFFF_FFFF_FFFF}};
                in_address = 9'd0;
                in_valid = 1'b1;
                inj = 1'b1;
                pend = 1'b1;
            end
            if (rst_beat >= 0 && pop_cnt >= rst_beat) begin
                mon_en = 1'b0;
                rst_n = 1'b0;
                @(posedge clk); #1;
                rst_n = 1'b1;
                chk("rst_m_valid", m_valid, 0);
                chk("rst_busy", busy, 0);
                chk("rst_overflow", overflow, 0);
                sbq.delete();
                mon_en = 1'b1;
                return;
            end
            if (!busy) done = 1'b1;
        end
        if (!done) begin
            n_cmp++; n_fail++;
            $display("FAIL drain_timeout: busy still %0b after %0d cycles", busy, n);
        end
        chk("drain_all_popped", sbq.size(), 0);
        chk("drain_end_valid", m_valid, 0);
        if (exp_cycles > 0) chk("drain_cycles", n, exp_cycles);
    endtask

    // Random back-pressure, changed just after each rising edge.
    initial begin
        m_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            m_ready = ($urandom_range(0, 99) < ready_pct);
        end
    end

    // Scoreboard monitor: a beat transfers at the rising edge following this falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (prev_stall) begin
                chk("stall_valid", m_valid, 1);
                chk("stall_data", m_data, prev_data);
                chk("stall_last", m_last, prev_last);
            end
            if (m_valid && m_ready) begin
                if (sbq.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL unexpected_beat: got data %0h, expected no beat", m_data);
                end else begin
                    e = sbq.pop_front();
                    chk("m_data", m_data, e.data);
                    chk("m_last", m_last, e.last);
                    pop_cnt++;
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        scen_t tbl[5];
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_address = 9'd0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("reset_busy", busy, 0);
        chk("reset_overflow", overflow, 0);
        chk("reset_m_valid", m_valid, 0);
        chk("reset_m_last", m_last, 0);
        chk("reset_m_data", m_data, 0);
        mon_en = 1'b1;

        tbl[0] = '{1'b0, 0, 100, -1,   -1, 4097, 1'b0};
        tbl[1] = '{1'b0, 1,  60, -1,   -1,    0, 1'b0};
        tbl[2] = '{1'b1, 2, 100, 100,  -1, 4097, 1'b1};
        tbl[3] = '{1'b0, 3,  75, -1, 2000,    0, 1'b0};
        tbl[4] = '{1'b0, 4, 100, -1,   -1, 4097, 1'b0};
        for (int t = 0; t < 5; t++) begin
            ready_pct = tbl[t].ready_pct;
            pop_cnt = 0;
            for (int a = 0; a < 32; a++) send_beat(tbl[t].rev_addr ? 31 - a : a, tbl[t].salt);
            chk("busy_after_load", busy, 1);
            chk("no_valid_yet", m_valid, 0);
            push_expected();
            drain(tbl[t].ovf_beat, tbl[t].rst_beat, tbl[t].exp_cycles);
            chk("overflow_end", overflow, tbl[t].exp_ovf);
        end

        // Descending addresses, then a frame opening with a stray beat that is later overwritten.
        ready_pct = 100;
        pop_cnt = 0;
        for (int a = 31; a >= 0; a--) send_beat(a, 10);
        push_expected();
        drain(-1, -1, 4097);
        send_beat(5, 11);
        for (int a = 0; a < 30; a++) send_beat(a, 12);
        chk("busy_before_32nd", busy, 0);
        send_beat(30, 12);
        chk("busy_after_32nd", busy, 1);
        push_expected();
        ready_pct = 50;
        drain(-1, -1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
